// File: rtl/pmp_napot_scheduler_if.sv
// Request, response and configuration bus of the PMP NAPOT scheduler.
// The requester (LSU/fetch path plus config writer) drives the master side;
// the scheduler sits on the slave side.
interface pmp_napot_scheduler_if #(
    parameter int IDXW = 3
) ();
    logic            cfg_we;
    logic            addr_we;
    logic [IDXW-1:0] cfg_idx;
    logic [7:0]      cfg_data;
    logic [31:0]     cfg_data_a;
    logic            cfg_ready;

    logic            chk_valid;
    logic            chk_ready;
    logic [31:0]     chk_addr;
    logic [1:0]      chk_size;
    logic [1:0]      chk_type;
    logic            chk_mmode;

    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_allow;
    logic            rsp_hit;
    logic [IDXW-1:0] rsp_idx;

    modport master (
        output cfg_we, addr_we, cfg_idx, cfg_data, cfg_data_a,
        input  cfg_ready,
        output chk_valid, chk_addr, chk_size, chk_type, chk_mmode,
        input  chk_ready,
        input  rsp_valid, rsp_allow, rsp_hit, rsp_idx,
        output rsp_ready
    );

    modport slave (
        input  cfg_we, addr_we, cfg_idx, cfg_data, cfg_data_a,
        output cfg_ready,
        input  chk_valid, chk_addr, chk_size, chk_type, chk_mmode,
        output chk_ready,
        output rsp_valid, rsp_allow, rsp_hit, rsp_idx,
        input  rsp_ready
    );
endinterface

// File: rtl/pmp_napot_scheduler.sv
// Multi-entry PMP checker that time-multiplexes one external NAPOT matcher.
// Entries are scanned one per cycle from 0 upward; the lowest matching entry
// decides. Optional feature macro: PMP_TOR_EN enables TOR (A=01) entries with
// an internal 33-bit range comparator; without it A=01 behaves as OFF.
module pmp_napot_scheduler #(
    parameter int N_ENTRIES = 8,
    localparam int IDXW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pmp_napot_scheduler_if.slave        bus,
    output logic [31:0]                 m_addr,
    output logic [31:0]                 m_addr_n,
    output logic [1:0]                  m_size,
    input  logic                        m_match
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    // Stored cfg keeps only meaningful bits: {L, A[1:0], X, W, R}.
    localparam int CFG_L = 5;

    state_t          state_q, state_d;
    logic [IDXW-1:0] scan_idx_q, scan_idx_d;
    logic [31:0]     addr_q, addr_d;
    logic [1:0]      size_q, size_d;
    logic [1:0]      type_q, type_d;
    logic            mmode_q, mmode_d;
    logic            illegal_q, illegal_d;
    logic            allow_q, allow_d;
    logic            hit_q, hit_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic [5:0]      cfg_q     [N_ENTRIES];
    logic [31:0]     pmpaddr_q [N_ENTRIES];

    logic [5:0]      curCfg;
    logic [1:0]      curMode;
    logic            curPerm;
    logic            hitAllow;
    logic            torMatch;
    logic            entryMatch;
    logic            lastEntry;
    logic            addrLockedByTor [N_ENTRIES];

    assign curCfg    = cfg_q[scan_idx_q];
    assign curMode   = curCfg[4:3];
    assign lastEntry = (scan_idx_q == IDXW'(N_ENTRIES - 1));

`ifdef PMP_TOR_EN
    logic [31:0] torLo;
    logic [32:0] torTop;

    // Range check for TOR entries; the top address is chk_addr plus the raw
    // size code, and a carry into bit 32 can never be below the bound.
    always_comb begin
        torLo    = (scan_idx_q == '0) ? 32'd0 : pmpaddr_q[IDXW'(scan_idx_q - 1'b1)];
        torTop   = {1'b0, addr_q} + {31'd0, size_q};
        torMatch = ({1'b0, addr_q} >= {1'b0, torLo}) &&
                   (torTop < {1'b0, pmpaddr_q[scan_idx_q]});
    end

    // A locked TOR entry also freezes the pmpaddr just below it (its base).
    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            addrLockedByTor[i] = 1'b0;
        end
        for (int i = 0; i < N_ENTRIES - 1; i++) begin
            addrLockedByTor[i] = cfg_q[i+1][CFG_L] && (cfg_q[i+1][4:3] == 2'b01);
        end
    end
`else
    assign torMatch = 1'b0;

    // Without TOR support no entry can protect its neighbour's address.
    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            addrLockedByTor[i] = 1'b0;
        end
    end
`endif

    // Per-entry match and permission decision for the entry under scan.
    always_comb begin
        case (curMode)
            2'b11:   entryMatch = m_match;
            2'b01:   entryMatch = torMatch;
            default: entryMatch = 1'b0;
        endcase
        case (type_q)
            2'b00:   curPerm = curCfg[0];
            2'b01:   curPerm = curCfg[1];
            default: curPerm = curCfg[2];
        endcase
        hitAllow = curCfg[CFG_L] ? curPerm : (mmode_q | curPerm);
    end

    // Next-state logic: accept, scan one entry per cycle, then hold the result.
    // Illegal requests still pass through one SCAN cycle so their response
    // timing matches a hit on entry 0, but no entry is evaluated.
    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        addr_d     = addr_q;
        size_d     = size_q;
        type_d     = type_q;
        mmode_d    = mmode_q;
        illegal_d  = illegal_q;
        allow_d    = allow_q;
        hit_d      = hit_q;
        idx_d      = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.chk_valid) begin
                    addr_d     = bus.chk_addr;
                    size_d     = bus.chk_size;
                    type_d     = bus.chk_type;
                    mmode_d    = bus.chk_mmode;
                    scan_idx_d = '0;
                    illegal_d  = (bus.chk_size == 2'b11) || (bus.chk_type == 2'b11);
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (illegal_q) begin
                    allow_d = 1'b0;
                    hit_d   = 1'b0;
                    idx_d   = '0;
                    state_d = RESP;
                end else if (entryMatch) begin
                    allow_d = hitAllow;
                    hit_d   = 1'b1;
                    idx_d   = scan_idx_q;
                    state_d = RESP;
                end else if (lastEntry) begin
                    allow_d = mmode_q;
                    hit_d   = 1'b0;
                    idx_d   = '0;
                    state_d = RESP;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            scan_idx_q <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            type_q     <= '0;
            mmode_q    <= 1'b0;
            illegal_q  <= 1'b0;
            allow_q    <= 1'b0;
            hit_q      <= 1'b0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            type_q     <= type_d;
            mmode_q    <= mmode_d;
            illegal_q  <= illegal_d;
            allow_q    <= allow_d;
            hit_q      <= hit_d;
            idx_q      <= idx_d;
        end
    end

    // Config writes land only in IDLE, so a scan always sees a stable table;
    // locked entries ignore both cfg and address writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                cfg_q[i]     <= '0;
                pmpaddr_q[i] <= '0;
            end
        end else if (state_q == IDLE) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if ((bus.cfg_idx == IDXW'(i)) && !cfg_q[i][CFG_L]) begin
                    if (bus.cfg_we) begin
                        cfg_q[i] <= {bus.cfg_data[7], bus.cfg_data[4:0]};
                    end
                    if (bus.addr_we && !addrLockedByTor[i]) begin
                        pmpaddr_q[i] <= bus.cfg_data_a;
                    end
                end
            end
        end
    end

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.chk_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_allow = allow_q;
    assign bus.rsp_hit   = hit_q;
    assign bus.rsp_idx   = idx_q;

    assign m_addr   = addr_q;
    assign m_size   = size_q;
    assign m_addr_n = pmpaddr_q[scan_idx_q];

endmodule

// File: tb/tb_pmp_napot_scheduler.sv
// Directed testbench for pmp_napot_scheduler (N_ENTRIES = 8).
// The external NAPOT matcher is modelled as an address-equality match against
// a bench-chosen pmpaddr value, so only the entry holding that value matches.
module tb_pmp_napot_scheduler;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m_addr;
    logic [31:0] m_addr_n;
    logic [1:0]  m_size;
    logic        m_match;

    logic        matchEnable;
    logic [31:0] matchTarget;

    int compared   = 0;
    int mismatched = 0;
    int latency;

    pmp_napot_scheduler_if #(.IDXW(3)) bus ();

    pmp_napot_scheduler #(.N_ENTRIES(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .m_addr   (m_addr),
        .m_addr_n (m_addr_n),
        .m_size   (m_size),
        .m_match  (m_match)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Matcher model: combinational on the pmpaddr presented by the scheduler.
    assign m_match = matchEnable && (m_addr_n == matchTarget);

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: count it, and report tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Write cfg and/or pmpaddr of one entry during a single cycle.
    task automatic applyConfig(input int idx, input bit doCfg, input logic [7:0] cfg,
                               input bit doAddr, input logic [31:0] addr);
        @(negedge clk);
        bus.cfg_idx    = 3'(idx);
        bus.cfg_we     = doCfg;
        bus.cfg_data   = cfg;
        bus.addr_we    = doAddr;
        bus.cfg_data_a = addr;
        @(posedge clk);
        #1;
        bus.cfg_we  = 1'b0;
        bus.addr_we = 1'b0;
    endtask

    // Issue one check request and count edges after acceptance until rsp_valid.
    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] size,
                                 input logic [1:0] typ, input logic mmode,
                                 output int lat);
        @(negedge clk);
        bus.chk_valid = 1'b1;
        bus.chk_addr  = addr;
        bus.chk_size  = size;
        bus.chk_type  = typ;
        bus.chk_mmode = mmode;
        @(posedge clk);
        #1;
        bus.chk_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    // Compare the held response fields and the response latency.
    task automatic checkResponse(input string tag, input int lat, input int expLat,
                                 input logic expHit, input logic expAllow,
                                 input logic [2:0] expIdx);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_hit"},     32'(bus.rsp_hit),   32'(expHit));
        checkOutput({tag, "_allow"},   32'(bus.rsp_allow), 32'(expAllow));
        checkOutput({tag, "_idx"},     32'(bus.rsp_idx),   32'(expIdx));
    endtask

    // Accept the response and confirm the scheduler is ready again.
    task automatic releaseResponse(input string tag);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        checkOutput({tag, "_rsp_valid_cleared"}, 32'(bus.rsp_valid), 32'd0);
        checkOutput({tag, "_chk_ready_back"},    32'(bus.chk_ready), 32'd1);
    endtask

    initial begin
        bus.cfg_we     = 1'b0;
        bus.addr_we    = 1'b0;
        bus.cfg_idx    = '0;
        bus.cfg_data   = '0;
        bus.cfg_data_a = '0;
        bus.chk_valid  = 1'b0;
        bus.chk_addr   = '0;
        bus.chk_size   = '0;
        bus.chk_type   = '0;
        bus.chk_mmode  = 1'b0;
        bus.rsp_ready  = 1'b0;
        matchEnable    = 1'b0;
        matchTarget    = '0;
        rst_n          = 1'b0;

        // Reset values
        #1;
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_chk_ready", 32'(bus.chk_ready), 32'd1);
        checkOutput("reset_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        checkOutput("reset_rsp_hit",   32'(bus.rsp_hit),   32'd0);
        checkOutput("reset_rsp_allow", 32'(bus.rsp_allow), 32'd0);
        checkOutput("reset_rsp_idx",   32'(bus.rsp_idx),   32'd0);
        checkOutput("reset_m_addr",    m_addr,             32'd0);
        checkOutput("reset_m_size",    32'(m_size),        32'd0);
        checkOutput("reset_m_addr_n",  m_addr_n,           32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // All entries OFF, U-mode read: full scan, no hit, denied
        applyStimulus(32'h0000_0100, 2'b10, 2'b00, 1'b0, latency);
        checkResponse("all_off", latency, N, 1'b0, 1'b0, 3'd0);
        checkOutput("all_off_m_addr", m_addr, 32'h0000_0100);
        checkOutput("all_off_m_size", 32'(m_size), 32'd2);
        releaseResponse("all_off");

        // Entry 2 NAPOT RW, matcher hits only on its pmpaddr
        applyConfig(2, 1'b1, 8'h1B, 1'b1, 32'h0000_2222);
        matchTarget = 32'h0000_2222;
        matchEnable = 1'b1;
        applyStimulus(32'h0000_8888, 2'b10, 2'b00, 1'b0, latency);
        checkResponse("e2_read", latency, 3, 1'b1, 1'b1, 3'd2);
        releaseResponse("e2_read");
        applyStimulus(32'h0000_8888, 2'b01, 2'b01, 1'b0, latency);
        checkResponse("e2_write", latency, 3, 1'b1, 1'b1, 3'd2);
        releaseResponse("e2_write");
        applyStimulus(32'h0000_8888, 2'b10, 2'b10, 1'b0, latency);
        checkResponse("e2_exec_u", latency, 3, 1'b1, 1'b0, 3'd2);
        releaseResponse("e2_exec_u");
        applyStimulus(32'h0000_8888, 2'b10, 2'b10, 1'b1, latency);
        checkResponse("e2_exec_m", latency, 3, 1'b1, 1'b1, 3'd2);
        releaseResponse("e2_exec_m");

        // Entry 0 locked NAPOT read-only: lock binds M-mode too
        applyConfig(0, 1'b1, 8'h99, 1'b1, 32'h0000_3333);
        matchTarget = 32'h0000_3333;
        applyStimulus(32'h0000_4000, 2'b10, 2'b01, 1'b1, latency);
        checkResponse("e0_locked_mwrite", latency, 1, 1'b1, 1'b0, 3'd0);
        releaseResponse("e0_locked_mwrite");
        applyStimulus(32'h0000_4000, 2'b00, 2'b00, 1'b1, latency);
        checkResponse("e0_locked_mread", latency, 1, 1'b1, 1'b1, 3'd0);
        releaseResponse("e0_locked_mread");

        // Writes to the locked entry are ignored
        applyConfig(0, 1'b1, 8'h1F, 1'b1, 32'h0000_4444);
        applyStimulus(32'h0000_4000, 2'b10, 2'b01, 1'b1, latency);
        checkResponse("e0_write_ignored", latency, 1, 1'b1, 1'b0, 3'd0);
        releaseResponse("e0_write_ignored");

        // Illegal size: immediate denial, response held while rsp_ready is low;
        // a config write attempted meanwhile must be dropped
        applyStimulus(32'h0000_3333, 2'b11, 2'b00, 1'b1, latency);
        checkResponse("illegal_size", latency, 1, 1'b0, 1'b0, 3'd0);
        bus.cfg_idx    = 3'd1;
        bus.cfg_we     = 1'b1;
        bus.cfg_data   = 8'h1B;
        bus.addr_we    = 1'b1;
        bus.cfg_data_a = 32'h0000_2222;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("hold_chk_ready", 32'(bus.chk_ready), 32'd0);
            checkOutput("hold_cfg_ready", 32'(bus.cfg_ready), 32'd0);
            checkOutput("hold_rsp_allow", 32'(bus.rsp_allow), 32'd0);
            checkOutput("hold_rsp_hit",   32'(bus.rsp_hit),   32'd0);
        end
        bus.cfg_we  = 1'b0;
        bus.addr_we = 1'b0;
        releaseResponse("illegal_size");

        // Illegal type, then prove the dropped write to entry 1 never landed
        applyStimulus(32'h0000_3333, 2'b00, 2'b11, 1'b1, latency);
        checkResponse("illegal_type", latency, 1, 1'b0, 1'b0, 3'd0);
        releaseResponse("illegal_type");
        matchTarget = 32'h0000_2222;
        applyStimulus(32'h0000_8888, 2'b10, 2'b00, 1'b0, latency);
        checkResponse("dropped_write", latency, 3, 1'b1, 1'b1, 3'd2);
        releaseResponse("dropped_write");

        // No match in M-mode: allowed by default
        matchEnable = 1'b0;
        applyStimulus(32'h0000_5000, 2'b00, 2'b10, 1'b1, latency);
        checkResponse("nomatch_m", latency, N, 1'b0, 1'b1, 3'd0);
        releaseResponse("nomatch_m");

        // Reset asserted while the scan sits on entry 3
        @(negedge clk);
        bus.chk_valid = 1'b1;
        bus.chk_addr  = 32'h0000_5555;
        bus.chk_size  = 2'b10;
        bus.chk_type  = 2'b00;
        bus.chk_mmode = 1'b0;
        @(posedge clk);
        #1;
        bus.chk_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midscan_m_addr_before", m_addr, 32'h0000_5555);
        rst_n = 1'b0;
        #1;
        checkOutput("midscan_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("midscan_chk_ready", 32'(bus.chk_ready), 32'd1);
        checkOutput("midscan_m_addr",    m_addr,             32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Config table cleared: former hits on entries 0 and 2 now miss
        matchEnable = 1'b1;
        matchTarget = 32'h0000_3333;
        applyStimulus(32'h0000_4000, 2'b10, 2'b00, 1'b0, latency);
        checkResponse("cleared_e0", latency, N, 1'b0, 1'b0, 3'd0);
        releaseResponse("cleared_e0");
        matchTarget = 32'h0000_2222;
        applyStimulus(32'h0000_8888, 2'b10, 2'b00, 1'b0, latency);
        checkResponse("cleared_e2", latency, N, 1'b0, 1'b0, 3'd0);
        releaseResponse("cleared_e2");
        matchEnable = 1'b0;

`ifdef PMP_TOR_EN
        // TOR entry 1 covers [0x1000, 0x2000)
        applyConfig(0, 1'b0, 8'h00, 1'b1, 32'h0000_1000);
        applyConfig(1, 1'b1, 8'h0F, 1'b1, 32'h0000_2000);
        applyStimulus(32'h0000_1FFC, 2'b10, 2'b00, 1'b0, latency);
        checkResponse("tor_inside", latency, 2, 1'b1, 1'b1, 3'd1);
        releaseResponse("tor_inside");
        applyStimulus(32'h0000_1FFE, 2'b10, 2'b00, 1'b0, latency);
        checkResponse("tor_past_top", latency, N, 1'b0, 1'b0, 3'd0);
        releaseResponse("tor_past_top");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
